flux_track_engine: RTL and testbench
====================================

// Module: flux_track_engine
// PURPOSE
// Parametrised head-side bit-cell engine for the drive track buffer: walks a
// byte-wide track RAM one bit cell at a time with fractional cell timing and
// emits flux pulses. Turns write-gate pulses into read-modify-write byte
// updates and tracks dirty 512-byte chunks so only modified LBAs are saved.
// Replaces the fixed-width bit loop inside the track loader.
// PARAMETERS
// ADDR_W    13  track RAM byte address width
// INT_W     8   integer bits of cell_delay (clk cycles)
// FRAC_W    8   fractional bits of cell_delay
// PULSE_LO  1   cell counter value at which the flux pulse starts
// PULSE_HI  8   cell counter value at which the flux pulse ends
// MAX_ZEROS 3   zero cells before weak-bit noise is emitted (counter 2 bits min)
// CHUNK_SH  9   log2 bytes per dirty chunk
// CHUNKS    16  dirty_mask width
// PORTS
// clk           in  1                clock; all logic on posedge
// reset         in  1                synchronous, active-high
// en            in  1                motor on; 0 freezes all state
// cell_delay    in  INT_W+FRAC_W     clk cycles per cell, unsigned fixed point
// track_len     in  ADDR_W+1         track length in bytes
// load          in  1                1-cycle strobe: reposition head
// load_bit_pos  in  ADDR_W+3         new bit position for load
// rnd_bit       in  1                random bit for weak-bit noise
// wr_en         in  1                write gate active
// wr_flux       in  1                raw write flux from drive electronics
// flux_out      out 1                read flux pulse
// index_out     out 1                1-cycle pulse on track wrap
// bit_pos       out ADDR_W+3         current bit position
// ram_addr      out ADDR_W           = bit_pos[ADDR_W+2:3], combinational
// ram_q         in  8                RAM read data, 1-cycle latency
// ram_d         out 8                RAM write data
// ram_we        out 1                RAM write strobe
// dirty_mask    out CHUNKS           bit n set = chunk n written since clear
// dirty_clr     in  1                clear dirty_mask
// BEHAVIOUR
// - Reset: bit_pos=0, cnt=0, frac=0, {cnt_max,frac}=cell_delay-2^FRAC_W,
//   zero_run=0, wr latch=0, flux_out=0, index_out=0, ram_we=0, dirty_mask=0.
// - en=0: cnt/bit_pos/frac frozen, flux_out=0, ram_we=0, index_out=0.
// - Cell timer: cnt counts 0..cnt_max (cnt_max+1 cycles). Boundary when
//   cnt==cnt_max: cnt<=0, {cnt_max,frac}<={0,frac}+cell_delay-2^FRAC_W
//   (fraction carries so mean cell length = cell_delay exactly).
//   Legal range: cell_delay >= (PULSE_HI+3)*2^FRAC_W; below is undefined.
// - Advance at boundary: bit_pos+1. If new byte index >= track_len ->
//   bit_pos=0 and index_out=1 for that cycle. track_len=0 -> bit_pos held 0,
//   no flux, no writes.
// - Read: at cnt==PULSE_LO sample b=ram_q[7-bit_pos[2:0]].
//   b=1: flux_out<=1, zero_run<=0. b=0 and zero_run==MAX_ZEROS:
//   flux_out<=rnd_bit, zero_run held. else flux_out<=0, zero_run+1.
//   At cnt==PULSE_HI flux_out<=0. flux_out forced 0 while wr_en.
// - Write: rising edge of wr_flux (registered previous value) sets a sticky
//   latch during the cell. At boundary with wr_en=1: ram_we=1 for 1 cycle,
//   ram_addr still the old byte, ram_d=ram_q with bit 7-bit_pos[2:0]
//   replaced by latch (edge in boundary cycle counts). Latch cleared.
//   dirty_mask[ram_addr>>CHUNK_SH] set (index >= CHUNKS ignored).
// - load: bit_pos<=load_bit_pos (0 if byte index >= track_len), cnt=0,
//   frac=0, cnt_max reloaded, zero_run=0, latch cleared, flux_out=0.
//   load beats a same-cycle boundary: no advance, no write, no index_out.
// - dirty_clr with same-cycle write: mask becomes only the new bit.
// - Reset mid-cell or mid-write: ram_we low next cycle; no partial write.
// TESTING
// T1 cell_delay=64.0, track_len=2, RAM=80,00: flux_out high cnt 2..8 of
//    cell 0 only; cells 64 clk; after 16 cells index_out 1 pulse, bit_pos=0.
// T2 all-zero RAM, rnd_bit=1: no pulse cells 0-2, pulse every cell from 3;
//    a byte 0xFF resets run to 0.
// T3 cell_delay=64.5: cell lengths alternate 64/65; 200 cells = 12900 clk.
// T4 wr_en=1, wr_flux edge in cell bit_pos=29 (byte 3, bit 5), ram 0x00:
//    one ram_we, ram_addr=3, ram_d=0x04; dirty_mask=0x0001; at byte
//    0x200 -> 0x0003; dirty_clr same cycle as byte-0x400 write -> 0x0004.
// T5 load with load_bit_pos past track_len at cnt==cnt_max -> bit_pos=0,
//    no ram_we, no index_out; en=0 mid-cell freezes cnt/bit_pos.
// T6 reset asserted in boundary cycle with wr_en=1 -> ram_we=0, all outputs
//    at reset values next cycle.

Source files
------------

// File: rtl/flux_track_engine.sv
// Head-side bit-cell engine: walks a byte-wide track RAM with fractional cell timing,
// emits read flux pulses, folds write flux into read-modify-write bytes, tracks dirty chunks.
module flux_track_engine #(
  parameter int unsigned ADDR_W    = 13,
  parameter int unsigned INT_W     = 8,
  parameter int unsigned FRAC_W    = 8,
  parameter int unsigned PULSE_LO  = 1,
  parameter int unsigned PULSE_HI  = 8,
  parameter int unsigned MAX_ZEROS = 3,
  parameter int unsigned CHUNK_SH  = 9,
  parameter int unsigned CHUNKS    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [INT_W+FRAC_W-1:0] cell_delay,
  input  logic [ADDR_W:0]         track_len,
  input  logic                    load,
  input  logic [ADDR_W+2:0]       load_bit_pos,
  input  logic                    rnd_bit,
  input  logic                    wr_en,
  input  logic                    wr_flux,
  output logic                    flux_out,
  output logic                    index_out,
  output logic [ADDR_W+2:0]       bit_pos,
  output logic [ADDR_W-1:0]       ram_addr,
  input  logic [7:0]              ram_q,
  output logic [7:0]              ram_d,
  output logic                    ram_we,
  output logic [CHUNKS-1:0]       dirty_mask,
  input  logic                    dirty_clr
);
  localparam int unsigned BP_W = ADDR_W + 3;
  localparam int unsigned CD_W = INT_W + FRAC_W;
  localparam int unsigned ZR_W = ($clog2(MAX_ZEROS + 1) < 2) ? 2 : $clog2(MAX_ZEROS + 1);

  logic [BP_W-1:0]   bit_pos_q, bit_pos_d;
  logic [INT_W-1:0]  cnt_q, cnt_d, cnt_max_q, cnt_max_d;
  logic [FRAC_W-1:0] frac_q, frac_d;
  logic [ZR_W-1:0]   zero_run_q, zero_run_d;
  logic              latch_q, latch_d, wr_prev_q, wr_prev_d;
  logic              flux_q, flux_d, index_q, index_d;
  logic [CHUNKS-1:0] dirty_q, dirty_d;
  logic [CD_W-1:0]   reload_val, acc_next;
  logic [BP_W:0]     adv_pos;
  logic [2:0]        sel;
  logic [ADDR_W-1:0] chunk_idx;
  logic              boundary, wr_edge, wr_bit, track_empty, load_in_range, we_c;

  // Cell length in cycles minus one, with the fraction carried between cells
  assign reload_val    = cell_delay - (CD_W'(1) << FRAC_W);
  assign acc_next      = {INT_W'(0), frac_q} + reload_val;
  assign adv_pos       = {1'b0, bit_pos_q} + (BP_W+1)'(1);
  assign sel           = ~bit_pos_q[2:0];
  assign ram_addr      = bit_pos_q[BP_W-1:3];
  assign chunk_idx     = ram_addr >> CHUNK_SH;
  assign track_empty   = (track_len == '0);
  assign load_in_range = ({1'b0, load_bit_pos[BP_W-1:3]} < track_len);
  assign boundary      = (cnt_q == cnt_max_q);
  assign wr_edge       = wr_flux & ~wr_prev_q;
  assign wr_bit        = latch_q | wr_edge;

  always_comb begin
    bit_pos_d  = bit_pos_q;
    cnt_d      = cnt_q;
    cnt_max_d  = cnt_max_q;
    frac_d     = frac_q;
    zero_run_d = zero_run_q;
    latch_d    = latch_q;
    wr_prev_d  = wr_prev_q;
    flux_d     = flux_q;
    index_d    = 1'b0;
    dirty_d    = dirty_q;
    we_c       = 1'b0;
    ram_d      = ram_q;

    if (dirty_clr) dirty_d = '0;

    if (load) begin
      // Reposition wins over any boundary in the same cycle
      bit_pos_d              = load_in_range ? load_bit_pos : '0;
      cnt_d                  = '0;
      {cnt_max_d, frac_d}    = reload_val;
      zero_run_d             = '0;
      latch_d                = 1'b0;
      flux_d                 = 1'b0;
      if (en) wr_prev_d = wr_flux;
    end else if (!en) begin
      flux_d = 1'b0;
    end else begin
      wr_prev_d = wr_flux;
      latch_d   = wr_bit;

      if (cnt_q == INT_W'(PULSE_LO)) begin
        if (ram_q[sel]) begin
          flux_d     = 1'b1;
          zero_run_d = '0;
        end else if (zero_run_q == ZR_W'(MAX_ZEROS)) begin
          flux_d = rnd_bit;
        end else begin
          flux_d     = 1'b0;
          zero_run_d = zero_run_q + ZR_W'(1);
        end
      end
      if (cnt_q == INT_W'(PULSE_HI)) flux_d = 1'b0;

      if (boundary) begin
        cnt_d               = '0;
        {cnt_max_d, frac_d} = acc_next;
        latch_d             = 1'b0;
        if (!track_empty) begin
          // Write back the byte under the head before it moves on
          if (wr_en) begin
            we_c       = 1'b1;
            ram_d[sel] = wr_bit;
            for (int unsigned i = 0; i < CHUNKS; i++) begin
              if (32'(chunk_idx) == i) dirty_d[i] = 1'b1;
            end
          end
          if (adv_pos[BP_W:3] >= track_len) begin
            bit_pos_d = '0;
            index_d   = 1'b1;
          end else begin
            bit_pos_d = adv_pos[BP_W-1:0];
          end
        end
      end else begin
        cnt_d = cnt_q + INT_W'(1);
      end

      if (track_empty) begin
        bit_pos_d = '0;
        flux_d    = 1'b0;
      end
      if (wr_en) flux_d = 1'b0;
    end
  end

  assign ram_we = we_c & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_pos_q            <= '0;
      cnt_q                <= '0;
      {cnt_max_q, frac_q}  <= reload_val;
      zero_run_q           <= '0;
      latch_q              <= 1'b0;
      wr_prev_q            <= 1'b0;
      flux_q               <= 1'b0;
      index_q              <= 1'b0;
      dirty_q              <= '0;
    end else begin
      bit_pos_q  <= bit_pos_d;
      cnt_q      <= cnt_d;
      cnt_max_q  <= cnt_max_d;
      frac_q     <= frac_d;
      zero_run_q <= zero_run_d;
      latch_q    <= latch_d;
      wr_prev_q  <= wr_prev_d;
      flux_q     <= flux_d;
      index_q    <= index_d;
      dirty_q    <= dirty_d;
    end
  end

  assign flux_out   = flux_q;
  assign index_out  = index_q;
  assign bit_pos    = bit_pos_q;
  assign dirty_mask = dirty_q;
endmodule

// File: tb/tb_flux_track_engine.sv
// Self-checking bench for flux_track_engine: directed corner sequences, a write-vector
// table, and random runs against a per-cell arithmetic reference model.
module tb_flux_track_engine;
  logic        clk = 1'b0;
  logic        reset, en, load, rnd_bit, wr_en, wr_flux, dirty_clr;
  logic [15:0] cell_delay, load_bit_pos, bit_pos, dirty_mask;
  logic [13:0] track_len;
  logic        flux_out, index_out, ram_we;
  logic [12:0] ram_addr;
  logic [7:0]  ram_q, ram_d;

  logic [7:0]  mem [0:8191];
  logic [7:0]  img [0:8191];
  logic        pre_we = 1'b0;
  logic [12:0] pre_addr = '0;
  logic [7:0]  pre_data = '0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  flux_track_engine dut (
    .clk(clk), .reset(reset), .en(en), .cell_delay(cell_delay), .track_len(track_len),
    .load(load), .load_bit_pos(load_bit_pos), .rnd_bit(rnd_bit), .wr_en(wr_en),
    .wr_flux(wr_flux), .flux_out(flux_out), .index_out(index_out), .bit_pos(bit_pos),
    .ram_addr(ram_addr), .ram_q(ram_q), .ram_d(ram_d), .ram_we(ram_we),
    .dirty_mask(dirty_mask), .dirty_clr(dirty_clr)
  );

  // Track RAM with one-cycle read latency; bench preloads take priority
  always @(posedge clk) begin
    ram_q <= mem[ram_addr];
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (ram_we) mem[ram_addr] <= ram_d;
  end

  typedef struct {
    logic [15:0] lbp;
    int          mode;
    logic [12:0] addr;
    logic [7:0]  d;
    logic [15:0] mask;
  } wr_vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic poke(input logic [12:0] a, input logic [7:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    tick();
    pre_we   = 1'b0;
    img[a]   = d;
  endtask

  task automatic do_reset(input logic [15:0] cd, input logic [13:0] tl);
    reset = 1'b1; en = 1'b1; cell_delay = cd; track_len = tl; load = 1'b0;
    load_bit_pos = '0; wr_en = 1'b0; wr_flux = 1'b0; dirty_clr = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    wr_vec_t vecs [4];
    int hi_cnt, first_hi, last_hi, idx_cnt, we_cnt;
    int t_c1, t_c2, t_200;
    logic [20:0] got2, exp2;
    logic [12:0] got_addr;
    logic [7:0]  got_d;

    vecs[0] = '{16'd29,   1, 13'h003, 8'h04, 16'h0001};
    vecs[1] = '{16'h1000, 2, 13'h200, 8'h80, 16'h0003};
    vecs[2] = '{16'd47,   0, 13'h005, 8'hFE, 16'h0003};
    vecs[3] = '{16'h3FFB, 1, 13'h7FF, 8'h5A, 16'h000B};

    reset = 1'b1; en = 1'b0; cell_delay = 16'h1000; track_len = 14'd2; load = 1'b0;
    load_bit_pos = '0; rnd_bit = 1'b0; wr_en = 1'b0; wr_flux = 1'b0; dirty_clr = 1'b0;
    tick();

    // Reset values
    do_reset(16'h1000, 14'd2);
    chk("rst_bit_pos", 64'(bit_pos), 64'd0);
    chk("rst_flux", 64'(flux_out), 64'd0);
    chk("rst_index", 64'(index_out), 64'd0);
    chk("rst_dirty", 64'(dirty_mask), 64'd0);
    chk("rst_we", 64'(ram_we), 64'd0);

    // T1: one pulse in cell 0, wrap after 16 cells of 64 clocks
    poke(13'd0, 8'h80);
    poke(13'd1, 8'h00);
    rnd_bit = 1'b0;
    do_reset(16'h4000, 14'd2);
    hi_cnt = 0; first_hi = -1; last_hi = -1; idx_cnt = 0;
    for (int c = 0; c < 1024; c++) begin
      if (flux_out) begin
        hi_cnt++;
        if (first_hi < 0) first_hi = c;
        last_hi = c;
      end
      if (index_out) idx_cnt++;
      tick();
    end
    chk("t1_flux_cycles", 64'(hi_cnt), 64'd7);
    chk("t1_flux_first", 64'(first_hi), 64'd2);
    chk("t1_flux_last", 64'(last_hi), 64'd8);
    chk("t1_no_early_index", 64'(idx_cnt), 64'd0);
    chk("t1_index_pulse", 64'(index_out), 64'd1);
    chk("t1_wrap_pos", 64'(bit_pos), 64'd0);
    tick();
    chk("t1_index_one_cycle", 64'(index_out), 64'd0);

    // T2: weak-bit noise after three zero cells, reset by a 0xFF byte
    poke(13'd0, 8'h00);
    poke(13'd1, 8'hFF);
    poke(13'd2, 8'h00);
    poke(13'd3, 8'h00);
    rnd_bit = 1'b1;
    do_reset(16'h1000, 14'd4);
    got2 = '0;
    for (int c = 0; c < 16 * 21; c++) begin
      if (c % 16 == 2) got2[c / 16] = flux_out;
      tick();
    end
    for (int i = 0; i < 21; i++) exp2[i] = !(i <= 2 || (i >= 16 && i <= 18));
    chk("t2_pulse_cells", 64'(got2), 64'(exp2));

    // T3: 64.5-clock cells alternate 64/65
    rnd_bit = 1'b0;
    do_reset(16'h4080, 14'd100);
    t_c1 = -1; t_c2 = -1; t_200 = -1;
    for (int c = 0; c < 14000 && t_200 < 0; c++) begin
      if (bit_pos == 16'd1 && t_c1 < 0) t_c1 = c;
      if (bit_pos == 16'd2 && t_c2 < 0) t_c2 = c;
      if (bit_pos == 16'd200) t_200 = c;
      tick();
    end
    chk("t3_cell0_len", 64'(t_c1), 64'd64);
    chk("t3_cell1_end", 64'(t_c2), 64'd129);
    chk("t3_200_cells", 64'(t_200), 64'd12900);

    // T4: write-vector table
    poke(13'h003, 8'h00);
    poke(13'h200, 8'h00);
    poke(13'h005, 8'hFF);
    poke(13'h7FF, 8'h4A);
    poke(13'h400, 8'h00);
    do_reset(16'h1000, 14'h2000);
    for (int i = 0; i < 4; i++) begin
      load_bit_pos = vecs[i].lbp;
      load = 1'b1;
      tick();
      load = 1'b0;
      chk($sformatf("t4_load_pos[%0d]", i), 64'(bit_pos), 64'(vecs[i].lbp));
      we_cnt = 0; got_addr = '0; got_d = '0;
      for (int k = 0; k < 16; k++) begin
        wr_en   = 1'b1;
        wr_flux = (vecs[i].mode == 1 && k >= 5 && k < 8) || (vecs[i].mode == 2 && k == 15);
        #1;
        if (ram_we) begin
          we_cnt++;
          got_addr = ram_addr;
          got_d    = ram_d;
        end
        tick();
      end
      wr_en = 1'b0; wr_flux = 1'b0;
      chk($sformatf("t4_we_count[%0d]", i), 64'(we_cnt), 64'd1);
      chk($sformatf("t4_addr[%0d]", i), 64'(got_addr), 64'(vecs[i].addr));
      chk($sformatf("t4_data[%0d]", i), 64'(got_d), 64'(vecs[i].d));
      chk($sformatf("t4_dirty[%0d]", i), 64'(dirty_mask), 64'(vecs[i].mask));
    end

    // dirty_clr in the same cycle as a chunk-2 write leaves only that chunk
    load_bit_pos = 16'h2000;
    load = 1'b1;
    tick();
    load = 1'b0;
    we_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      wr_en = 1'b1;
      dirty_clr = (k == 15);
      #1;
      if (ram_we) we_cnt++;
      tick();
    end
    wr_en = 1'b0; dirty_clr = 1'b0;
    chk("t4_clr_we_count", 64'(we_cnt), 64'd1);
    chk("t4_clr_dirty", 64'(dirty_mask), 64'h0004);

    // T5: load past track end on a boundary; en=0 freezes the cell timer
    do_reset(16'h1000, 14'd2);
    for (int k = 0; k < 15; k++) tick();
    wr_en = 1'b1; load = 1'b1; load_bit_pos = 16'd100;
    #1;
    chk("t5_no_we_on_load", 64'(ram_we), 64'd0);
    tick();
    load = 1'b0; wr_en = 1'b0;
    chk("t5_load_clamp", 64'(bit_pos), 64'd0);
    chk("t5_no_index", 64'(index_out), 64'd0);
    for (int k = 0; k < 5; k++) tick();
    en = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    chk("t5_freeze_flux", 64'(flux_out), 64'd0);
    en = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    chk("t5_frozen_pos", 64'(bit_pos), 64'd0);
    tick();
    chk("t5_late_advance", 64'(bit_pos), 64'd1);

    // T6: reset landing on a write boundary suppresses the write
    do_reset(16'h1000, 14'd2);
    wr_en = 1'b1;
    for (int k = 0; k < 15; k++) tick();
    #1;
    chk("t6_first_write", 64'(ram_we), 64'd1);
    tick();
    chk("t6_dirty_set", 64'(dirty_mask), 64'h0001);
    for (int k = 16; k < 31; k++) tick();
    reset = 1'b1;
    #1;
    chk("t6_we_blocked", 64'(ram_we), 64'd0);
    tick();
    reset = 1'b0; wr_en = 1'b0;
    chk("t6_pos", 64'(bit_pos), 64'd0);
    chk("t6_dirty", 64'(dirty_mask), 64'd0);
    chk("t6_flux", 64'(flux_out), 64'd0);
    chk("t6_index", 64'(index_out), 64'd0);

    // Random configurations against a per-cell reference model
    for (int it = 0; it < 4; it++) begin
      logic [15:0] cd;
      int          len, n, run, cnt, p;
      longint      s_cur, s_next;
      logic        pulse, rb, b;
      logic [17:0] exp_v, got_v;
      cd  = 16'($urandom_range(11 * 256, 24 * 256));
      len = $urandom_range(1, 4);
      for (int a = 0; a < len; a++) begin
        logic [7:0] d;
        d = 8'($urandom & $urandom);
        if ($urandom_range(0, 2) == 0) d = 8'h00;
        poke(13'(a), d);
      end
      do_reset(cd, 14'(len));
      n = 0; run = 0; pulse = 1'b0; s_cur = 0;
      s_next = longint'(cd) >> 8;
      for (int c = 0; c < 2500; c++) begin
        if (longint'(c) == s_next) begin
          n++;
          s_cur  = s_next;
          s_next = (longint'(n + 1) * longint'(cd)) >> 8;
        end
        cnt   = c - int'(s_cur);
        p     = n % (8 * len);
        exp_v = {(pulse && cnt >= 2 && cnt <= 8), (cnt == 0 && n > 0 && p == 0), 16'(p)};
        got_v = {flux_out, index_out, bit_pos};
        chk($sformatf("rand%0d_c%0d", it, c), 64'(got_v), 64'(exp_v));
        rb = 1'($urandom);
        rnd_bit = rb;
        if (cnt == 1) begin
          b = img[p / 8][7 - (p % 8)];
          if (b) begin
            pulse = 1'b1;
            run   = 0;
          end else if (run == 3) begin
            pulse = rb;
          end else begin
            pulse = 1'b0;
            run++;
          end
        end
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
